uart_hex_packetizer: RTL and testbench

UART_HEX_PACKETIZER -- requirements
Module: uart_hex_packetizer

---
 rtl/uart_hex_packetizer.sv | 128 ++++++++++++
 tb/tb_uart_hex_packetizer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_packetizer.sv
// Turns each accepted word into ASCII hex characters (MSB nibble first, optional CR LF)
// and hands them one at a time to a UART transmitter using a start/done handshake.
module uart_hex_packetizer #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADD_CRLF       = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  word_Valid,
  input  logic [WORD_WIDTH-1:0] word_Data,
  output logic                  word_Ready,
  input  logic                  tx_Done,
  output logic [7:0]            tx_Data,
  output logic                  tx_Start,
  output logic                  busy,
  output logic [15:0]           word_Count,
  output logic                  err_Timeout
);

  localparam int NIB     = WORD_WIDTH / 4;
  localparam int N_CHARS = NIB + 2 * ADD_CRLF;
  localparam int IDX_W   = 5;
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, NEXT} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      nidx;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [15:0]           count_q, count_d;
  logic                  done_q;
  logic                  done_rise;
  logic                  wd_expired;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign done_rise  = tx_Done & ~done_q;
  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES));
  assign nidx       = idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    wd_d      = wd_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (word_Valid) begin
          tx_data_d = hex_char(word_Data[WORD_WIDTH-1 -: 4]);
          shift_d   = {word_Data[WORD_WIDTH-5:0], 4'h0};
          idx_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A completing edge wins over a watchdog expiring in the same cycle.
        if (done_rise) begin
          state_d = NEXT;
        end else if (wd_expired) begin
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      NEXT: begin
        if (idx_q == IDX_W'(N_CHARS - 1)) begin
          count_d = count_q + 16'd1;
          state_d = IDLE;
        end else begin
          idx_d   = nidx;
          state_d = ISSUE;
          if (nidx < IDX_W'(NIB)) begin
            tx_data_d = hex_char(shift_q[WORD_WIDTH-1 -: 4]);
            shift_d   = {shift_q[WORD_WIDTH-5:0], 4'h0};
          end else if (nidx == IDX_W'(NIB)) begin
            tx_data_d = 8'h0D;
          end else begin
            tx_data_d = 8'h0A;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tx_data_q <= 8'h00;
      wd_q      <= '0;
      count_q   <= 16'h0000;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      wd_q      <= wd_d;
      count_q   <= count_d;
      done_q    <= tx_Done;
    end
  end

  // Payload shift register carries no control meaning, so it is not reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign word_Ready  = ~reset & (state_q == IDLE);
  assign tx_Start    = ~reset & (state_q == ISSUE);
  assign busy        = ~reset & (state_q != IDLE);
  assign tx_Data     = reset ? 8'h00 : tx_data_q;
  assign word_Count  = reset ? 16'h0000 : count_q;
  assign err_Timeout = ~reset & (state_q == WAIT_DONE) & ~done_rise & wd_expired;

endmodule

// File: tb/tb_uart_hex_packetizer.sv
// Directed bench for uart_hex_packetizer: character stream, back-to-back words,
// level-style done, watchdog abort, mid-word reset and word counter wrap.
module tb_uart_hex_packetizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        d_valid, d_ready, d_start, d_busy, d_err;
  logic        d_done = 1'b0;
  logic [31:0] d_data;
  logic [7:0]  d_txd;
  logic [15:0] d_cnt;

  logic        t_valid, t_ready, t_start, t_busy, t_err, t_done;
  logic [31:0] t_data;
  logic [7:0]  t_txd;
  logic [15:0] t_cnt;

  logic        w_valid, w_ready, w_start, w_busy, w_err, w_done;
  logic [7:0]  w_data;
  logic [7:0]  w_txd;
  logic [15:0] w_cnt;

  int tests = 0;
  int fails = 0;

  uart_hex_packetizer dut (
    .clk(clk), .reset(rst), .word_Valid(d_valid), .word_Data(d_data), .word_Ready(d_ready),
    .tx_Done(d_done), .tx_Data(d_txd), .tx_Start(d_start), .busy(d_busy),
    .word_Count(d_cnt), .err_Timeout(d_err)
  );

  uart_hex_packetizer #(.TIMEOUT_CYCLES(100)) dut_to (
    .clk(clk), .reset(rst), .word_Valid(t_valid), .word_Data(t_data), .word_Ready(t_ready),
    .tx_Done(t_done), .tx_Data(t_txd), .tx_Start(t_start), .busy(t_busy),
    .word_Count(t_cnt), .err_Timeout(t_err)
  );

  uart_hex_packetizer #(.WORD_WIDTH(8), .ADD_CRLF(0)) dut_w (
    .clk(clk), .reset(rst), .word_Valid(w_valid), .word_Data(w_data), .word_Ready(w_ready),
    .tx_Done(w_done), .tx_Data(w_txd), .tx_Start(w_start), .busy(w_busy),
    .word_Count(w_cnt), .err_Timeout(w_err)
  );

  // Transmitter model for dut: raises tx_Done mdl_delay cycles after tx_Start (or after
  // the previous level drops) and holds it for mdl_hold cycles; records every character.
  int         mdl_delay = 20;
  int         mdl_hold  = 1;
  bit         mdl_en    = 1'b0;
  int         flush_req = 0;
  int         flush_ack = 0;
  logic [7:0] chars[$];
  int         n_start   = 0;
  int         stab_err  = 0;
  logic [7:0] last_data = 8'h00;
  int         pend = 0, wait_c = 0, hold_c = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (flush_ack != flush_req) begin
        chars.delete();
        d_done = 1'b0; pend = 0; wait_c = 0; hold_c = 0;
        n_start = 0; stab_err = 0;
        flush_ack = flush_req;
      end else begin
        if (wait_c > 0) wait_c--;
        if (d_done) begin
          hold_c--;
          if (hold_c <= 0) d_done = 1'b0;
        end else if (pend != 0 && wait_c == 0 && mdl_en) begin
          d_done = 1'b1; hold_c = mdl_hold; pend = 0;
        end
        if (d_start === 1'b1) begin
          chars.push_back(d_txd);
          n_start++; pend = 1; wait_c = mdl_delay; last_data = d_txd;
        end else if (d_busy === 1'b1 && d_txd !== last_data) begin
          stab_err++;
        end
      end
    end
  end

  task automatic mdl_flush();
    flush_req++;
    for (int i = 0; i < 5 && flush_ack != flush_req; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (d_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", d_ready); end
    tests++; if (d_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", d_busy); end
    tests++; if (d_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", d_start); end
    tests++; if (d_txd !== 8'h00) begin fails++; $display("FAIL reset_txdata: got %h want 00", d_txd); end
    tests++; if (d_cnt !== 16'h0000) begin fails++; $display("FAIL reset_count: got %h want 0000", d_cnt); end
    tests++; if (d_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", d_err); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (d_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", d_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_q[$];
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    mdl_delay = 20; mdl_hold = 1; mdl_en = 1'b1;
    mdl_flush();
    d_data = 32'h1234ABCD; d_valid = 1'b1;
    tests++; if (d_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b want 1", d_ready); end
    @(negedge clk);
    d_valid = 1'b0;
    tests++; if (d_start !== 1'b1) begin fails++; $display("FAIL basic_start_latency: got %b want 1", d_start); end
    tests++; if (d_txd !== 8'h31) begin fails++; $display("FAIL basic_first_char: got %h want 31", d_txd); end
    for (int i = 0; i < 1000 && d_cnt !== 16'd1; i++) @(negedge clk);
    @(negedge clk);
    tests++; if (d_cnt !== 16'd1) begin fails++; $display("FAIL basic_count: got %0d want 1", d_cnt); end
    tests++; if (n_start != 10) begin fails++; $display("FAIL basic_starts: got %0d want 10", n_start); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (i >= chars.size() || chars[i] !== exp_q[i]) begin
        fails++; $display("FAIL basic_char%0d: got %h want %h", i, (i < chars.size()) ? chars[i] : 8'hxx, exp_q[i]);
      end
    end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL basic_txdata_stable: got %0d changes want 0", stab_err); end
    tests++; if (d_busy !== 1'b0 || d_ready !== 1'b1) begin fails++; $display("FAIL basic_idle: busy %b ready %b want 0 1", d_busy, d_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int cyc, starts, ready_cyc, second_cyc;
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A,
              8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    mdl_delay = 20; mdl_hold = 1; mdl_en = 1'b1;
    mdl_flush();
    d_data = 32'h1234ABCD; d_valid = 1'b1;
    @(negedge clk);
    d_data = 32'hFFFFFFFF;
    cyc = 0; starts = 1; ready_cyc = -1; second_cyc = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cyc++;
      if (d_ready === 1'b1 && ready_cyc < 0) ready_cyc = cyc;
      if (d_start === 1'b1) starts++;
      if (starts == 11) begin second_cyc = cyc; break; end
    end
    d_valid = 1'b0;
    tests++; if (ready_cyc != 220) begin fails++; $display("FAIL b2b_ready_cycle: got %0d want 220", ready_cyc); end
    tests++; if (second_cyc != 221) begin fails++; $display("FAIL b2b_period: got %0d want 221", second_cyc); end
    for (int i = 0; i < 1000 && d_cnt !== 16'd3; i++) @(negedge clk);
    @(negedge clk);
    tests++; if (d_cnt !== 16'd3) begin fails++; $display("FAIL b2b_count: got %0d want 3", d_cnt); end
    tests++; if (chars.size() != 20) begin fails++; $display("FAIL b2b_nchars: got %0d want 20", chars.size()); end
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (i >= chars.size() || chars[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_char%0d: got %h want %h", i, (i < chars.size()) ? chars[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_level();
    logic [7:0] exp_q[$];
    exp_q = '{8'h30, 8'h46, 8'h30, 8'h46, 8'h35, 8'h41, 8'h35, 8'h41, 8'h0D, 8'h0A};
    mdl_delay = 5; mdl_hold = 50; mdl_en = 1'b1;
    mdl_flush();
    d_data = 32'h0F0F5A5A; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    for (int i = 0; i < 3000 && d_cnt !== 16'd4; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    tests++; if (d_cnt !== 16'd4) begin fails++; $display("FAIL level_count: got %0d want 4", d_cnt); end
    tests++; if (n_start != 10) begin fails++; $display("FAIL level_starts: got %0d want 10", n_start); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (i >= chars.size() || chars[i] !== exp_q[i]) begin
        fails++; $display("FAIL level_char%0d: got %h want %h", i, (i < chars.size()) ? chars[i] : 8'hxx, exp_q[i]);
      end
    end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL level_txdata_stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_timeout();
    int cyc, starts;
    t_data = 32'hDEADBEEF; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    tests++; if (t_start !== 1'b1 || t_txd !== 8'h44) begin fails++; $display("FAIL to_first_start: start %b data %h want 1 44", t_start, t_txd); end
    cyc = 0; starts = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (t_start === 1'b1) starts++;
      if (t_err === 1'b1) break;
    end
    tests++; if (cyc != 101) begin fails++; $display("FAIL to_err_cycle: got %0d want 101", cyc); end
    tests++; if (starts != 0) begin fails++; $display("FAIL to_extra_starts: got %0d want 0", starts); end
    @(negedge clk);
    tests++; if (t_err !== 1'b0) begin fails++; $display("FAIL to_err_width: got %b want 0", t_err); end
    tests++; if (t_busy !== 1'b0 || t_ready !== 1'b1) begin fails++; $display("FAIL to_idle: busy %b ready %b want 0 1", t_busy, t_ready); end
    tests++; if (t_cnt !== 16'd0) begin fails++; $display("FAIL to_count: got %0d want 0", t_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_q[$];
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    mdl_delay = 20; mdl_hold = 1; mdl_en = 1'b1;
    mdl_flush();
    d_data = 32'h1234ABCD; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    for (int i = 0; i < 200 && n_start < 3; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++; if (d_start !== 1'b0 || d_txd !== 8'h00) begin fails++; $display("FAIL rmid_tx%0d: start %b data %h want 0 00", k, d_start, d_txd); end
      tests++; if (d_ready !== 1'b0 || d_busy !== 1'b0 || d_err !== 1'b0) begin fails++; $display("FAIL rmid_ctl%0d: ready %b busy %b err %b want 0 0 0", k, d_ready, d_busy, d_err); end
      tests++; if (d_cnt !== 16'd0) begin fails++; $display("FAIL rmid_count%0d: got %0d want 0", k, d_cnt); end
    end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (d_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready_after: got %b want 1", d_ready); end
    mdl_flush();
    d_data = 32'h00000000; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    for (int i = 0; i < 1000 && d_cnt !== 16'd1; i++) @(negedge clk);
    @(negedge clk);
    tests++; if (d_cnt !== 16'd1) begin fails++; $display("FAIL rmid_next_count: got %0d want 1", d_cnt); end
    tests++; if (n_start != 10) begin fails++; $display("FAIL rmid_next_starts: got %0d want 10", n_start); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (i >= chars.size() || chars[i] !== exp_q[i]) begin
        fails++; $display("FAIL rmid_char%0d: got %h want %h", i, (i < chars.size()) ? chars[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  first_chars[2];
    logic [15:0] cnt_at_last;
    bit          lost;
    int          k;
    first_chars[0] = 8'h00; first_chars[1] = 8'h00;
    cnt_at_last = 16'h0000; lost = 1'b0;
    w_data = 8'hA5; w_valid = 1'b1;
    for (int w = 0; w < 65536 && !lost; w++) begin
      for (int c = 0; c < 2; c++) begin
        k = 0;
        while (w_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) begin lost = 1'b1; break; end
        if (w == 0) first_chars[c] = w_txd;
        if (w == 65535 && c == 0) begin cnt_at_last = w_cnt; w_valid = 1'b0; end
        @(negedge clk); w_done = 1'b1;
        @(negedge clk); w_done = 1'b0;
      end
    end
    w_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (lost) begin fails++; $display("FAIL wrap_start_timeout: got lost start want none"); end
    tests++; if (first_chars[0] !== 8'h41 || first_chars[1] !== 8'h35) begin fails++; $display("FAIL wrap_chars: got %h %h want 41 35", first_chars[0], first_chars[1]); end
    tests++; if (cnt_at_last !== 16'hFFFF) begin fails++; $display("FAIL wrap_pre: got %h want ffff", cnt_at_last); end
    tests++; if (w_cnt !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h want 0000", w_cnt); end
    tests++; if (w_busy !== 1'b0) begin fails++; $display("FAIL wrap_idle: got busy %b want 0", w_busy); end
  endtask

  initial begin
    rst = 1'b1;
    d_valid = 1'b0; d_data = 32'h0;
    t_valid = 1'b0; t_data = 32'h0; t_done = 1'b0;
    w_valid = 1'b0; w_data = 8'h0; w_done = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_level();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
